// File: rtl/router_fifo.sv
// router_fifo: per-destination byte FIFO that tracks packet boundaries and zeroes data_out once a packet drains.
// Latency: a write clears empty 1 cycle later; data_out is registered 1 cycle after an accepted read_enb.
// Backpressure: write_enb while full is dropped; read_enb while empty is ignored; soft_reset purges everything.
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_busy
);

    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] dat;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [5:0]      byte_cnt;
    logic            wr_fire;
    logic            rd_fire;
    entry_t          rd_entry;
    logic [5:0]      hdr_len;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign wr_fire  = write_enb && !full && !soft_reset;
    assign rd_fire  = read_enb && !empty && !soft_reset;
    assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];
    assign hdr_len  = rd_entry.dat[7:2];
    assign pkt_busy = (byte_cnt != 6'd0);

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_ptr[ADDR_W-1:0]] <= '{hdr: lfd_state, dat: data_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Header byte carries payload length in [7:2]; +1 accounts for the trailing parity byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt <= 6'd0;
            data_out <= '0;
        end else if (soft_reset) begin
            byte_cnt <= 6'd0;
            data_out <= '0;
        end else if (rd_fire) begin
            data_out <= rd_entry.dat;
            if (rd_entry.hdr) begin
                byte_cnt <= hdr_len + 6'd1;
            end else if (byte_cnt != 6'd0) begin
                byte_cnt <= byte_cnt - 6'd1;
            end
        end else if (byte_cnt == 6'd0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: packet read-out, full/drop, wrap, soft and async reset.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    int total = 0;
    int bad   = 0;

    router_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic hdr, input logic [7:0] b);
        write_enb = 1'b1;
        lfd_state = hdr;
        data_in   = b;
        read_enb  = 1'b0;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
        read_enb = 1'b0; data_in = 8'h00;
        #12;
        total++;
        if (data_out !== 8'h00 || full !== 1'b0 || empty !== 1'b1 || pkt_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state data_out=%h full=%b empty=%b pkt_busy=%b required 00/0/1/0",
                     data_out, full, empty, pkt_busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_packet();
        logic [7:0] exp_b [5];
        logic       exp_busy [5];
        exp_b    = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h1C};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        push(1'b1, 8'h0C);
        total++;
        if (empty !== 1'b0) begin
            bad++; $display("FAIL pkt_empty_deassert empty=%b required 0", empty);
        end
        push(1'b0, 8'h11); push(1'b0, 8'h22); push(1'b0, 8'h33); push(1'b0, 8'h1C);
        for (int i = 0; i < 5; i++) begin
            read_enb = 1'b1;
            tick();
            total++;
            if (data_out !== exp_b[i]) begin
                bad++; $display("FAIL pkt_rd%0d data_out=%h required %h", i, data_out, exp_b[i]);
            end
            total++;
            if (pkt_busy !== exp_busy[i]) begin
                bad++; $display("FAIL pkt_busy%0d pkt_busy=%b required %b", i, pkt_busy, exp_busy[i]);
            end
        end
        read_enb = 1'b0;
        tick();
        total++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            bad++; $display("FAIL pkt_drain data_out=%h empty=%b required 00/1", data_out, empty);
        end
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        total++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            bad++; $display("FAIL rd_when_empty data_out=%h empty=%b required 00/1", data_out, empty);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 8'(8'h40 + i));
            if (i == 14) begin
                total++;
                if (full !== 1'b0) begin
                    bad++; $display("FAIL full_at15 full=%b required 0", full);
                end
            end
        end
        total++;
        if (full !== 1'b1) begin
            bad++; $display("FAIL full_at16 full=%b required 1", full);
        end
        push(1'b0, 8'hAA);
        total++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            bad++; $display("FAIL full_drop full=%b empty=%b required 1/0", full, empty);
        end
    endtask

    task automatic test_full_rdwr();
        write_enb = 1'b1; data_in = 8'hBB; read_enb = 1'b1;
        tick();
        write_enb = 1'b0; read_enb = 1'b0;
        total++;
        if (data_out !== 8'h40) begin
            bad++; $display("FAIL full_rdwr_data data_out=%h required 40", data_out);
        end
        total++;
        if (full !== 1'b0) begin
            bad++; $display("FAIL full_rdwr_flag full=%b required 0", full);
        end
        for (int i = 1; i < 16; i++) begin
            read_enb = 1'b1;
            tick();
            total++;
            if (data_out !== 8'(8'h40 + i)) begin
                bad++; $display("FAIL full_rd%0d data_out=%h required %h", i, data_out, 8'(8'h40 + i));
            end
        end
        read_enb = 1'b0;
        tick();
        total++;
        if (empty !== 1'b1 || data_out !== 8'h00) begin
            bad++; $display("FAIL full_after_drain empty=%b data_out=%h required 1/00", empty, data_out);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] v;
        logic [7:0] exp_v;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            v = 8'(8'h80 + n * 7); n++;
            push(1'b0, v);
            q.push_back(v);
        end
        for (int i = 0; i < 40; i++) begin
            v = 8'(8'h80 + n * 7); n++;
            write_enb = 1'b1; data_in = v; read_enb = 1'b1;
            tick();
            exp_v = q.pop_front();
            q.push_back(v);
            total++;
            if (data_out !== exp_v) begin
                bad++; $display("FAIL wrap_rd%0d data_out=%h required %h", i, data_out, exp_v);
            end
            total++;
            if (full !== 1'b0 || empty !== 1'b0) begin
                bad++; $display("FAIL wrap_flags%0d full=%b empty=%b required 0/0", i, full, empty);
            end
        end
        write_enb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_enb = 1'b1;
            tick();
            exp_v = q.pop_front();
            total++;
            if (data_out !== exp_v) begin
                bad++; $display("FAIL wrap_tail%0d data_out=%h required %h", i, data_out, exp_v);
            end
        end
        read_enb = 1'b0;
        tick();
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL wrap_empty empty=%b required 1", empty);
        end
    endtask

    task automatic test_soft_reset();
        push(1'b1, 8'h0C);
        for (int i = 0; i < 7; i++) push(1'b0, 8'(8'h60 + i));
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        total++;
        if (data_out !== 8'h0C || pkt_busy !== 1'b1) begin
            bad++; $display("FAIL soft_pre data_out=%h pkt_busy=%b required 0C/1", data_out, pkt_busy);
        end
        soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h99; read_enb = 1'b1;
        tick();
        soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        total++;
        if (empty !== 1'b1 || pkt_busy !== 1'b0 || data_out !== 8'h00 || full !== 1'b0) begin
            bad++; $display("FAIL soft_purge empty=%b pkt_busy=%b data_out=%h full=%b required 1/0/00/0",
                            empty, pkt_busy, data_out, full);
        end
        tick();
        total++;
        if (empty !== 1'b1 || data_out !== 8'h00) begin
            bad++; $display("FAIL soft_write_ignored empty=%b data_out=%h required 1/00", empty, data_out);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_b [3];
        logic       exp_busy [3];
        exp_b    = '{8'h04, 8'h5A, 8'h5E};
        exp_busy = '{1'b1, 1'b1, 1'b0};
        push(1'b1, 8'h0C); push(1'b0, 8'h11); push(1'b0, 8'h22);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        total++;
        if (data_out !== 8'h0C || pkt_busy !== 1'b1 || empty !== 1'b0) begin
            bad++; $display("FAIL async_pre data_out=%h pkt_busy=%b empty=%b required 0C/1/0",
                            data_out, pkt_busy, empty);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if (data_out !== 8'h00 || empty !== 1'b1 || pkt_busy !== 1'b0 || full !== 1'b0) begin
            bad++; $display("FAIL async_reset data_out=%h empty=%b pkt_busy=%b full=%b required 00/1/0/0",
                            data_out, empty, pkt_busy, full);
        end
        #1 reset = 1'b0;
        push(1'b1, 8'h04); push(1'b0, 8'h5A); push(1'b0, 8'h5E);
        for (int i = 0; i < 3; i++) begin
            read_enb = 1'b1;
            tick();
            total++;
            if (data_out !== exp_b[i] || pkt_busy !== exp_busy[i]) begin
                bad++; $display("FAIL async_rd%0d data_out=%h pkt_busy=%b required %h/%b",
                                i, data_out, pkt_busy, exp_b[i], exp_busy[i]);
            end
        end
        read_enb = 1'b0;
        tick();
        total++;
        if (data_out !== 8'h00 || empty !== 1'b1) begin
            bad++; $display("FAIL async_drain data_out=%h empty=%b required 00/1", data_out, empty);
        end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full();
        test_full_rdwr();
        test_wrap();
        test_soft_reset();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
